instruction_fetch_unit: RTL and testbench

Fetch stage feeding the program ROM and the decode stage.
- Holds the program counter and drives the ROM address.
- Captures the returned instruction into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, and flags out-of-range or misaligned fetch addresses.
- Sits directly upstream of the program memory (drives its Address) and consumes its Instruction output.

---
 rtl/instruction_fetch_unit.sv | 118 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, addresses the program ROM and loads the IF/ID register.
// Handles stall, branch/jump redirect with flush, and a terminal fetch-address fault.
module instruction_fetch_unit #(
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter int unsigned            MEMORY_DEPTH = 1024,
    parameter logic [DATA_WIDTH-1:0]  TEXT_BASE    = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0]  NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [DATA_WIDTH-1:0] BranchTarget,
    input  logic                  Jump,
    input  logic [DATA_WIDTH-1:0] JumpTarget,
    output logic [DATA_WIDTH-1:0] FetchAddress,
    input  logic [DATA_WIDTH-1:0] Instruction,
    output logic [DATA_WIDTH-1:0] IFID_Instruction,
    output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
    output logic                  IFID_Valid,
    output logic                  AddressFault,
    output logic [DATA_WIDTH-1:0] FetchCount
);

    localparam int unsigned AW1 = DATA_WIDTH + 1;
    // One past the last ROM byte, held in one extra bit so a ROM ending at 2^32 cannot wrap.
    localparam logic [AW1-1:0] TEXT_END = {1'b0, TEXT_BASE} + AW1'(4 * MEMORY_DEPTH);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   ifid_instr_q, ifid_instr_d;
    logic [DATA_WIDTH-1:0]   ifid_pcp4_q, ifid_pcp4_d;
    logic                    ifid_valid_q, ifid_valid_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   fetch_count_q, fetch_count_d;
    logic [DATA_WIDTH-1:0]   pc_plus4_c;
    logic                    pc_fault_c;

    assign pc_plus4_c = pc_q + DATA_WIDTH'(4);
    assign pc_fault_c = (pc_q < TEXT_BASE)
                     || ({1'b0, pc_q} >= TEXT_END)
                     || (pc_q[1:0] != 2'b00);

    // Next-state and datapath selection.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ifid_instr_d  = ifid_instr_q;
        ifid_pcp4_d   = ifid_pcp4_q;
        ifid_valid_d  = ifid_valid_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            RUN: begin
                if (pc_fault_c) begin
                    state_d      = FAULT;
                    fault_d      = 1'b1;
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end else if (BranchTaken) begin
                    pc_d         = BranchTarget;
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end else if (Jump) begin
                    pc_d         = JumpTarget;
                    ifid_instr_d = NOP_WORD;
                    ifid_valid_d = 1'b0;
                end else if (!Stall) begin
                    pc_d          = pc_plus4_c;
                    ifid_instr_d  = Instruction;
                    ifid_pcp4_d   = pc_plus4_c;
                    ifid_valid_d  = 1'b1;
                    fetch_count_d = fetch_count_q + DATA_WIDTH'(1);
                end
            end
            FAULT: begin
                // Terminal: everything frozen until reset.
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            pc_q          <= TEXT_BASE;
            ifid_instr_q  <= NOP_WORD;
            ifid_pcp4_q   <= '0;
            ifid_valid_q  <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pcp4_q   <= ifid_pcp4_d;
            ifid_valid_q  <= ifid_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign FetchAddress     = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pcp4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign AddressFault     = fault_q;
    assign FetchCount       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: behavioural model plus directed literal checks.
module tb_instruction_fetch_unit;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BAD_RD = 32'hBADB_AD00;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] FetchAddress;
    logic [31:0] Instruction;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        AddressFault;
    logic [31:0] FetchCount;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_unit #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (DEPTH),
        .TEXT_BASE    (BASE),
        .NOP_WORD     (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .FetchAddress     (FetchAddress),
        .Instruction      (Instruction),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid),
        .AddressFault     (AddressFault),
        .FetchCount       (FetchCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rom_word(input int idx);
        if (idx == 0) return 32'h2008_0005;
        if (idx == 1) return 32'h2009_0003;
        return 32'hA000_0000 | 32'(idx);
    endfunction

    function automatic logic is_bad(input logic [31:0] addr);
        longint a;
        a = longint'(addr);
        return (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH) || (addr[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] rom_read(input logic [31:0] addr);
        if (is_bad(addr)) return BAD_RD;
        return rom_word(int'((addr - BASE) >> 2));
    endfunction

    // Combinational program ROM seen by the DUT.
    always_comb Instruction = rom_read(FetchAddress);

    // Reference model of the fetch stage, stated directly from the behavioural rules.
    logic [31:0] m_pc, m_instr, m_pcp4, m_count;
    logic        m_valid, m_fault;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc <= BASE; m_instr <= 32'h0; m_pcp4 <= 32'h0;
            m_valid <= 1'b0; m_fault <= 1'b0; m_count <= 32'h0;
        end else if (!m_fault) begin
            if (is_bad(m_pc)) begin
                m_fault <= 1'b1; m_instr <= 32'h0; m_valid <= 1'b0;
            end else if (BranchTaken || Jump) begin
                m_pc <= BranchTaken ? BranchTarget : JumpTarget;
                m_instr <= 32'h0; m_valid <= 1'b0;
            end else if (!Stall) begin
                m_instr <= rom_read(m_pc);
                m_pcp4  <= m_pc + 32'd4;
                m_pc    <= m_pc + 32'd4;
                m_valid <= 1'b1;
                m_count <= m_count + 32'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_fetch_address", FetchAddress, m_pc);
        check("m_ifid_instr", IFID_Instruction, m_instr);
        check("m_ifid_pcp4", IFID_PCPlus4, m_pcp4);
        check("m_ifid_valid", 32'(IFID_Valid), 32'(m_valid));
        check("m_fault", 32'(AddressFault), 32'(m_fault));
        check("m_count", FetchCount, m_count);
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] p4, input logic v, input logic f, input logic [31:0] cnt);
        check({tag, "_pc"}, FetchAddress, pc);
        check({tag, "_instr"}, IFID_Instruction, ins);
        check({tag, "_pcp4"}, IFID_PCPlus4, p4);
        check({tag, "_valid"}, 32'(IFID_Valid), 32'(v));
        check({tag, "_fault"}, 32'(AddressFault), 32'(f));
        check({tag, "_count"}, FetchCount, cnt);
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
        BranchTarget = 32'h0; JumpTarget = 32'h0;
        @(negedge clk);
        lit("reset", BASE, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Sequential fetch of the first two words.
        cyc();
        lit("fetch0", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 1'b0, 32'd1);
        cyc();
        lit("fetch1", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0, 32'd2);

        // Two-cycle stall holds everything, then resume.
        Stall = 1'b1;
        cyc();
        cyc();
        lit("stall", 32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1'b1, 1'b0, 32'd2);
        Stall = 1'b0;
        cyc();
        lit("resume", 32'h0040_000C, 32'hA000_0002, 32'h0040_000C, 1'b1, 1'b0, 32'd3);

        // Branch beats jump and stall; IF/ID flushed, PCPlus4 kept.
        BranchTaken = 1'b1; BranchTarget = 32'h0040_0040;
        Jump = 1'b1; JumpTarget = 32'h0040_0080; Stall = 1'b1;
        cyc();
        lit("branch", 32'h0040_0040, 32'h0, 32'h0040_000C, 1'b0, 1'b0, 32'd3);
        BranchTaken = 1'b0; Stall = 1'b0;

        // Jump near the top of ROM, then run off the end.
        JumpTarget = 32'h0040_0FF0;
        cyc();
        lit("jump", 32'h0040_0FF0, 32'h0, 32'h0040_000C, 1'b0, 1'b0, 32'd3);
        Jump = 1'b0;
        repeat (4) cyc();
        lit("last_word", 32'h0040_1000, 32'hA000_03FF, 32'h0040_1000, 1'b1, 1'b0, 32'd7);
        cyc();
        lit("end_fault", 32'h0040_1000, 32'h0, 32'h0040_1000, 1'b0, 1'b1, 32'd7);
        Jump = 1'b1; JumpTarget = 32'h0040_0000;
        cyc();
        cyc();
        lit("fault_hold", 32'h0040_1000, 32'h0, 32'h0040_1000, 1'b0, 1'b1, 32'd7);
        Jump = 1'b0;

        // Asynchronous reset in FAULT, checked before the next edge.
        @(posedge clk);
        #2 reset = 1'b0;
        #1 lit("async_rst", BASE, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Misaligned jump target faults one edge after it is loaded.
        cyc();
        lit("refetch", 32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1'b1, 1'b0, 32'd1);
        Jump = 1'b1; JumpTarget = 32'h0040_0002;
        cyc();
        lit("mis_load", 32'h0040_0002, 32'h0, 32'h0040_0004, 1'b0, 1'b0, 32'd1);
        Jump = 1'b0;
        cyc();
        lit("mis_fault", 32'h0040_0002, 32'h0, 32'h0040_0004, 1'b0, 1'b1, 32'd1);

        // Targets below the base and near 2^32 also fault.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        BranchTaken = 1'b1; BranchTarget = 32'h003F_FFFC;
        cyc();
        BranchTaken = 1'b0;
        cyc();
        lit("low_fault", 32'h003F_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        cyc();
        Jump = 1'b0;
        cyc();
        lit("high_fault", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b1, 32'd0);

        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
